// File: rtl/slave_port.sv
// Serial bus slave port: deserialises an LSB-first address/data frame, issues a
// parallel device request, and streams read data back with optional split.
module slave_port #(
   parameter int ADDR_WIDTH      = 12,
   parameter int DATA_WIDTH      = 8,
   parameter int SPLIT_THRESHOLD = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  swdata,
   input  logic                  smode,
   input  logic                  mvalid,
   output logic                  srdata,
   output logic                  svalid,
   output logic                  sready,
   output logic                  ssplit,
   input  logic                  split_grant,
   output logic [ADDR_WIDTH-1:0] daddr,
   output logic [DATA_WIDTH-1:0] dwdata,
   input  logic [DATA_WIDTH-1:0] drdata,
   output logic                  dmode,
   output logic                  dvalid,
   input  logic                  dready
);

   localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int WW      = (SPLIT_THRESHOLD > 1) ? $clog2(SPLIT_THRESHOLD) : 1;

   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(SPLIT_THRESHOLD - 1);
   localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_DEV,
      S_SPLIT,
      S_RESUME,
      S_RDATA
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_cnt;
   logic [WW-1:0]         r_wait;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_mode;

   logic [ADDR_WIDTH-1:0] w_addr_mask;
   logic [DATA_WIDTH-1:0] w_data_mask;
   logic                  w_addr_last;
   logic                  w_data_last;
   logic                  w_wait_last;

   // One-hot bit selects avoid index-width mismatches between r_cnt and the targets
   assign w_addr_mask = ADDR_WIDTH'(1) << r_cnt;
   assign w_data_mask = DATA_WIDTH'(1) << r_cnt;
   assign w_addr_last = (r_cnt == ADDR_LAST);
   assign w_data_last = (r_cnt == DATA_LAST);
   assign w_wait_last = (r_wait == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      sready = 1'b0;
      dvalid = 1'b0;
      ssplit = 1'b0;
      svalid = 1'b0;
      srdata = 1'b0;
      case (r_state)
         S_IDLE: begin
            sready = 1'b1;
            if (mvalid) w_next = S_ADDR;
         end
         S_ADDR: begin
            if (mvalid && w_addr_last) w_next = r_mode ? S_WDATA : S_DEV;
         end
         S_WDATA: begin
            if (mvalid && w_data_last) w_next = S_DEV;
         end
         S_DEV: begin
            dvalid = 1'b1;
            if (dready) begin
               w_next = r_mode ? S_IDLE : S_RDATA;
            end else if (!r_mode && w_wait_last) begin
               w_next = S_SPLIT;
            end
         end
         S_SPLIT: begin
            dvalid = 1'b1;
            ssplit = 1'b1;
            if (dready) w_next = S_RESUME;
         end
         S_RESUME: begin
            if (split_grant) w_next = S_RDATA;
         end
         S_RDATA: begin
            svalid = 1'b1;
            srdata = |(r_rdata & w_data_mask);
            if (w_data_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_mode  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mvalid) begin
                  r_addr <= ADDR_WIDTH'(swdata);
                  r_mode <= smode;
                  r_cnt  <= CNT_ONE;
               end
            end
            S_ADDR: begin
               if (mvalid) begin
                  r_addr <= swdata ? (r_addr | w_addr_mask) : (r_addr & ~w_addr_mask);
                  r_cnt  <= w_addr_last ? '0 : r_cnt + CNT_ONE;
               end
            end
            S_WDATA: begin
               if (mvalid) begin
                  r_wdata <= swdata ? (r_wdata | w_data_mask) : (r_wdata & ~w_data_mask);
                  r_cnt   <= w_data_last ? '0 : r_cnt + CNT_ONE;
               end
            end
            S_DEV, S_SPLIT: begin
               if (dready && !r_mode) r_rdata <= drdata;
            end
            S_RDATA: begin
               r_cnt <= w_data_last ? '0 : r_cnt + CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   // Wait counter only advances on stalled reads; any other cycle restarts it
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wait <= '0;
      end else if (r_state == S_DEV && !dready && !r_mode && !w_wait_last) begin
         r_wait <= r_wait + WAIT_ONE;
      end else begin
         r_wait <= '0;
      end
   end

   assign daddr  = r_addr;
   assign dwdata = r_wdata;
   assign dmode  = r_mode;

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: slave memory address width (serial address bits received).
REQ-002 Parameter DATA_WIDTH, default 8: data word width.
REQ-003 Parameter SPLIT_THRESHOLD, default 4: device-wait cycles on a read before split is requested.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 swdata  in  1  serial write data/address bit from bus.
REQ-007 smode  in  1  transfer mode, 0 read, 1 write; sampled with first address bit.
REQ-008 mvalid  in  1  swdata bit valid.
REQ-009 srdata  out  1  serial read data bit to bus.
REQ-010 svalid  out  1  srdata bit valid.
REQ-011 sready  out  1  port idle, can accept a new frame.
REQ-012 ssplit  out  1  split request to arbiter.
REQ-013 split_grant  in  1  arbiter has re-granted the split master.
REQ-014 daddr  out  ADDR_WIDTH  device address.
REQ-015 dwdata  out  DATA_WIDTH  device write data.
REQ-016 drdata  in  DATA_WIDTH  device read data.
REQ-017 dmode  out  1  device mode, 0 read, 1 write.
REQ-018 dvalid  out  1  device request valid.
REQ-019 dready  in  1  device accepts request / read data valid.

Function
REQ-020 Serial order SHALL be LSB first for address and data; a bit SHALL be consumed only on a cycle with mvalid=1; gaps of mvalid=0 SHALL stall without losing state.
REQ-021 States SHALL be IDLE, ADDR, WDATA, DEV, SPLIT, RESUME, RDATA.
REQ-022 IDLE: sready=1; on mvalid=1 capture swdata into daddr[0], smode into dmode, bit counter=1, go ADDR.
REQ-023 ADDR: each valid bit SHALL load daddr[counter]; after bit ADDR_WIDTH-1, counter=0 and go WDATA if dmode=1 else DEV.
REQ-024 WDATA: each valid bit SHALL load dwdata[counter]; after bit DATA_WIDTH-1 go DEV.
REQ-025 DEV: dvalid=1 with daddr/dwdata/dmode stable; transfer completes on the cycle dvalid=1 and dready=1.
REQ-026 Write completion in DEV SHALL return to IDLE next cycle; dvalid deasserts same edge.
REQ-027 Read completion in DEV SHALL latch drdata into an internal shift register and go RDATA (or RESUME if ssplit=1).
REQ-028 Read in DEV with dready=0 for SPLIT_THRESHOLD consecutive cycles SHALL set ssplit=1 and go SPLIT; dvalid stays 1.
REQ-029 SPLIT: on dready=1 latch drdata, drop dvalid, go RESUME; ssplit stays 1.
REQ-030 RESUME: ssplit deasserts on entry edge; wait for split_grant=1, then go RDATA.
REQ-031 RDATA: svalid=1 and srdata=latched bit[counter] on each of DATA_WIDTH consecutive cycles, no gaps; after bit DATA_WIDTH-1 go IDLE, svalid=0.
REQ-032 sready SHALL be 1 only in IDLE; mvalid outside IDLE/ADDR/WDATA SHALL be ignored.
REQ-033 Write latency: dvalid asserted the cycle after the last data bit; read: first svalid the cycle after drdata latched (no split).
REQ-034 dready=1 on the first DEV cycle SHALL complete with no split, regardless of SPLIT_THRESHOLD.
REQ-035 split_grant outside RESUME SHALL be ignored.

Reset
REQ-036 rstn=0 at a rising edge SHALL force IDLE from any state, including mid-frame.
REQ-037 Reset values: srdata=0, svalid=0, ssplit=0, sready=1 (combinational from IDLE), dvalid=0, dmode=0, daddr=0, dwdata=0, counters 0.
REQ-038 First frame after reset release SHALL be decoded with no residual bits.

Verification
REQ-039 Write: smode=1, address 0x5A3, data 0xC6 serial LSB first, dready=1 -> one cycle dvalid=1, daddr=0x5A3, dwdata=0xC6, dmode=1, then sready=1.
REQ-040 Read: address 0x010, dready=1 after 2 cycles, drdata=0x3B -> no ssplit; svalid 8 cycles, srdata 1,1,0,1,1,1,0,0.
REQ-041 Split: read, dready low 10 cycles, drdata=0xA5 -> ssplit=1 after 4 DEV cycles; holds until latch; svalid only after split_grant=1; bits 1,0,1,0,0,1,0,1.
REQ-042 Gapped: write frame with mvalid=0 inserted every other bit -> same dvalid/daddr/dwdata as uninterrupted frame.
REQ-043 Reset mid-frame after 5 address bits -> sready=1, dvalid=0 next cycle; subsequent write to 0xFFF data 0x01 decoded exactly.
REQ-044 Back-to-back: write completion followed immediately by read frame -> second frame starts the cycle sready=1, both transfers correct.
